div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start_i, input, 1 bit, divide request from EX; held high until result is consumed.
REQ-005 The block SHALL have port annul_i, input, 1 bit, abort the in-flight divide (pipeline flush).
REQ-006 The block SHALL have port signed_div_i, input, 1 bit: 1 means div and 0 means divu.
REQ-007 The block SHALL have port opdata1_i, input, 32 bits, dividend.
REQ-008 The block SHALL have port opdata2_i, input, 32 bits, divisor.
REQ-009 The block SHALL have port result_o, output, 64 bits: {remainder -> HI, quotient -> LO}.
REQ-010 The block SHALL have port ready_o, output, 1 bit, result_o valid.
REQ-011 The block SHALL have port stallreq_o, output, 1 bit, pipeline stall request.

Function
REQ-012 The FSM SHALL have states IDLE, BYZERO, ON and END.
REQ-013 In IDLE, when start_i=1 and annul_i=0, the block SHALL latch the operands and signed_div_i on that edge.
- Divisor=0: next state BYZERO.
- Otherwise: next state ON, with iteration counter cleared to 0.
REQ-014 While the FSM is in BYZERO or ON, the block SHALL ignore any operand change on its inputs.
REQ-015 BYZERO SHALL go to END on the next edge with result 64'h0.
REQ-016 ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit working register, for exactly 32 steps. The counter SHALL run 0..31; END SHALL be entered on the edge after step 31.
REQ-017 The latency SHALL be as follows:
- ready_o first high 34 cycles after the edge sampling start_i=1.
- 2 cycles for divide-by-zero.
REQ-018 Signed mode SHALL:
- operate on absolute values;
- negate the quotient when the operand signs differ;
- give the remainder the sign of the dividend;
- wrap 0x80000000 / 0xFFFFFFFF to quotient 0x80000000, remainder 0 (no trap).
REQ-019 In END, ready_o=1 and result_o SHALL hold stable until start_i=0 is sampled. The FSM SHALL then return to IDLE with ready_o=0 and result_o=0.
REQ-020 Outside END, ready_o SHALL be 0 and result_o SHALL be 0.
REQ-021 stallreq_o SHALL equal start_i & ~ready_o, combinationally.
REQ-022 annul_i=1 in any state SHALL force IDLE on the next edge and discard any partial result. If annul_i and start_i are both high in IDLE, the request SHALL NOT be accepted.
REQ-023 start_i held high through END SHALL NOT start a new divide. A new divide SHALL require at least one IDLE cycle.

Reset
REQ-024 On rst=1 the block SHALL set:
- state IDLE;
- counter 0;
- working register 0;
- result_o 0;
- ready_o 0.
REQ-025 Reset mid-divide SHALL abandon the operation with no result produced. stallreq_o SHALL follow REQ-021 from the first post-reset cycle.

Configuration
REQ-026 With macro DIV_SIGNED_EN defined, the block SHALL implement signed handling per REQ-018.
REQ-027 Without DIV_SIGNED_EN, the block SHALL ignore signed_div_i, perform all divides unsigned and instantiate no negation logic.

Structure
REQ-028 The shared package cpu_defs SHALL hold:
- the FSM state encoding (2 bits);
- DIV_CNT_MAX=32;
- the aluop codes DIV=8'b00011010 and DIVU=8'b00011011;
- the 64-bit result width constant.
REQ-029 One combinational sub-module div_step SHALL be used: one shift-subtract iteration, taking the 65-bit working register and divisor and returning the next working register.

Verification
REQ-030 The bench SHALL cover each of the following scenarios:
- divu 100/7: ready_o at cycle 34; result_o = {32'd2, 32'd14}; stallreq_o high cycles 0..33.
- div -7/2 (0xFFFFFFF9, 2) with DIV_SIGNED_EN: result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Without the macro: {0x00000001, 0x7FFFFFFC}.
- Divisor 0 (any dividend): ready_o at cycle 2; result_o = 0.
- annul_i pulse at step 10: IDLE next cycle; ready_o never rises; a fresh divu 9/3 then gives {0, 3}.
- start_i held 3 cycles in END: result stable; after start_i drops, one IDLE cycle; a second request is accepted normally.
- rst asserted at step 20: all outputs 0 next cycle; the subsequent divide is correct.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the sequential divider: FSM encoding,
// iteration bound, divide aluop codes and result width.
package cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BYZERO = 2'b01,
    ST_ON     = 2'b10,
    ST_END    = 2'b11
  } div_state_e;

  localparam int unsigned DIV_CNT_MAX = 32;
  localparam int unsigned DIV_CNT_W   = 6;

  localparam logic [7:0] ALUOP_DIV  = 8'b00011010;
  localparam logic [7:0] ALUOP_DIVU = 8'b00011011;

  localparam int unsigned RESULT_W = 64;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the 65-bit working register
// {partial remainder[32:0], dividend/quotient[31:0]}.
module div_step (
  input  logic [64:0] work_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] work_o
);

  logic [33:0] diff;

  // Shifted partial remainder minus divisor; bit 33 is the borrow.
  assign diff = work_i[64:31] - {2'b00, divisor_i};

  always_comb begin
    if (diff[33]) begin
      work_o = {work_i[63:0], 1'b0};
    end else begin
      work_o = {diff[32:0], work_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32/32 divider for the EX stage: result {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every divide is unsigned.
module div_seq
  import cpu_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [31:0]         opdata1_i,
  input  logic [31:0]         opdata2_i,
  output logic [RESULT_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  div_state_e                 state_q, state_d;
  logic [DIV_CNT_W-1:0]       cnt_q, cnt_d;
  logic [64:0]                work_q, work_d;
  logic [31:0]                divisor_q, divisor_d;
  logic [RESULT_W-1:0]        result_q, result_d;
  logic                       ready_q, ready_d;

  logic [64:0]                work_step;
  logic [31:0]                op1_abs, op2_abs;
  logic [31:0]                quo_fin, rem_fin;
  logic                       accept;

  assign accept = (state_q == ST_IDLE) & start_i & ~annul_i;

`ifdef DIV_SIGNED_EN
  logic op1_neg, op2_neg;
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign op1_neg = signed_div_i & opdata1_i[31];
  assign op2_neg = signed_div_i & opdata2_i[31];
  assign op1_abs = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_abs = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

  // Quotient negated on differing signs, remainder takes the dividend's sign.
  assign quo_fin = neg_quo_q ? (~work_q[31:0]  + 32'd1) : work_q[31:0];
  assign rem_fin = neg_rem_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      neg_quo_d = op1_neg ^ op2_neg;
      neg_rem_d = op1_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div_i;
  assign op1_abs           = opdata1_i;
  assign op2_abs           = opdata2_i;
  assign quo_fin           = work_q[31:0];
  assign rem_fin           = work_q[63:32];
`endif

  div_step u_div_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_step)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    ready_d   = 1'b0;
    result_d  = '0;

    if (annul_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      work_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            divisor_d = op2_abs;
            cnt_d     = '0;
            if (opdata2_i == 32'd0) begin
              state_d = ST_BYZERO;
              work_d  = '0;
            end else begin
              state_d = ST_ON;
              work_d  = {33'd0, op1_abs};
            end
          end
        end
        ST_BYZERO: begin
          state_d = ST_END;
          work_d  = '0;
        end
        ST_ON: begin
          // Counter sits at DIV_CNT_MAX for one cycle after step 31 before END.
          if (cnt_q != DIV_CNT_W'(DIV_CNT_MAX)) begin
            work_d = work_step;
            cnt_d  = cnt_q + DIV_CNT_W'(1);
          end else begin
            state_d = ST_END;
          end
        end
        ST_END: begin
          if (start_i) begin
            ready_d  = 1'b1;
            result_d = {rem_fin, quo_fin};
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, results, annul, reset and
// END hand-shake; signed expectations follow DIV_SIGNED_EN.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents a request sampled on the next rising edge.
  task automatic request(input logic [31:0] op1, input logic [31:0] op2, input logic sgn);
    opdata1_i    = op1;
    opdata2_i    = op2;
    signed_div_i = sgn;
    start_i      = 1'b1;
  endtask

  // Counts rising edges from the sampling edge until ready_o is seen, scrambling
  // the operand inputs meanwhile and checking stallreq_o on every waiting cycle.
  task automatic measure(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    int bad_stall;
    lat       = 0;
    bad_stall = 0;
    @(posedge clk);
    while (lat < 100) begin
      @(negedge clk);
      if (ready_o) break;
      if (stallreq_o !== 1'b1) bad_stall++;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~signed_div_i;
      @(posedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " stall while busy"}, 64'(bad_stall), 64'd0);
    check({tag, " stall when ready"}, {63'd0, stallreq_o}, 64'd0);
  endtask

  // Keeps start_i high for 'hold' more cycles, then drops it and checks the idle cycle.
  task automatic finish_req(input string tag, input int hold, input logic [63:0] exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " held result"}, result_o, exp_res);
      check({tag, " held ready"}, {63'd0, ready_o}, 64'd1);
    end
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle ready"}, {63'd0, ready_o}, 64'd0);
    check({tag, " idle result"}, result_o, 64'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                     input logic sgn, input int exp_lat, input logic [63:0] exp_res, input int hold);
    request(op1, op2, sgn);
    measure(tag, exp_lat, exp_res);
    finish_req(tag, hold, exp_res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_neg7_2;
    logic [63:0] exp_min_m1;
    logic [63:0] exp_7_m2;
    logic [63:0] exp_m7_m2;
    int          ready_seen;

`ifdef DIV_SIGNED_EN
    exp_neg7_2 = {32'hFFFFFFFF, 32'hFFFFFFFD};
    exp_min_m1 = {32'h00000000, 32'h80000000};
    exp_7_m2   = {32'h00000001, 32'hFFFFFFFD};
    exp_m7_m2  = {32'hFFFFFFFF, 32'h00000003};
`else
    exp_neg7_2 = {32'h00000001, 32'h7FFFFFFC};
    exp_min_m1 = {32'h80000000, 32'h00000000};
    exp_7_m2   = {32'h00000007, 32'h00000000};
    exp_m7_m2  = {32'hFFFFFFF9, 32'h00000000};
`endif

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stall", {63'd0, stallreq_o}, 64'd0);
    start_i = 1'b1;
    #1;
    check("reset stall follows start", {63'd0, stallreq_o}, 64'd1);
    start_i = 1'b0;
    rst     = 1'b0;
    @(negedge clk);

    run("divu 100/7", 32'd100, 32'd7, 1'b0, 34, {32'd2, 32'd14}, 0);
    run("div -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 34, exp_neg7_2, 0);
    run("divu by zero", 32'd12345, 32'd0, 1'b0, 2, 64'd0, 0);
    run("divu max/1", 32'hFFFFFFFF, 32'd1, 1'b0, 34, {32'd0, 32'hFFFFFFFF}, 0);
    run("divu 5/7", 32'd5, 32'd7, 1'b0, 34, {32'd5, 32'd0}, 0);
    run("div min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 34, exp_min_m1, 0);
    run("div 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 34, exp_7_m2, 0);
    run("div -7/-2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 34, exp_m7_m2, 0);
    run("div by zero", 32'hFFFFFFFB, 32'd0, 1'b1, 2, 64'd0, 0);

    // start_i held through END, then back-to-back request after one idle cycle
    run("hold 50000/123", 32'd50000, 32'd123, 1'b0, 34, {32'd62, 32'd406}, 3);
    run("after hold 1/1", 32'd1, 32'd1, 1'b0, 34, {32'd0, 32'd1}, 0);

    // annul at step 10; start_i stays high so the fresh request is taken straight from IDLE
    request(32'd1000, 32'd3, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    check("annul ready", {63'd0, ready_o}, 64'd0);
    check("annul result", result_o, 64'd0);
    request(32'd9, 32'd3, 1'b0);
    measure("post-annul divu 9/3", 34, {32'd0, 32'd3});
    finish_req("post-annul divu 9/3", 0, {32'd0, 32'd3});

    // start with annul in IDLE must not be accepted; acceptance happens one edge later
    request(32'd20, 32'd4, 1'b0);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    measure("annul+start 20/4", 34, {32'd0, 32'd5});
    finish_req("annul+start 20/4", 0, {32'd0, 32'd5});

    // synchronous reset at step 20 abandons the divide
    request(32'd778, 32'd7, 1'b0);
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid reset ready", {63'd0, ready_o}, 64'd0);
    check("mid reset result", result_o, 64'd0);
    check("mid reset stall", {63'd0, stallreq_o}, 64'd0);
    rst        = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o !== 1'b0) ready_seen++;
    end
    check("no result after reset", 64'(ready_seen), 64'd0);
    run("post-reset divu 778/7", 32'd778, 32'd7, 1'b0, 34, {32'd1, 32'd111}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
